fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; it is the producer end of the IF→ID interface.
- Owns the PC register and drives the synchronous instruction SRAM (1-cycle read latency).
- Consumes the branch redirect from ID and the stall vector from the pipeline controller.
- Presents ID with {ce, pc} plus an instruction word that stays stable across stalls, via an internal hold register, so ID needs no instruction-holding logic of its own.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency instruction
// SRAM and presents ID with {ce, pc} plus an instruction word that is held
// stable across pipeline stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          STALL_WD = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_WD-1:0] stall,
  input  logic [32:0]         br_bus,
  output logic [32:0]         if_to_id_bus,
  output logic                inst_sram_en,
  output logic [3:0]          inst_sram_wen,
  output logic [31:0]         inst_sram_addr,
  output logic [31:0]         inst_sram_wdata,
  input  logic [31:0]         inst_sram_rdata,
  output logic [31:0]         id_inst
);

  // The register sits one word before the first fetch so the first unstalled
  // edge after reset lands exactly on RESET_PC through the normal +4 path.
  localparam logic [31:0] PC_RST_VAL = RESET_PC - 32'd4;

  logic        br_e;
  logic [31:0] br_addr;
  logic        stall_pc;
  logic        stall_if;
  logic        stall_id;

  logic [31:0] pc_q,        pc_d;
  logic        ce_q,        ce_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        bubble_q,    bubble_d;

  logic [31:0] next_pc;

  // Later-stage stall bits are not relevant to fetch.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_WD-1:3];

  assign br_e     = br_bus[32];
  assign br_addr  = br_bus[31:0];
  assign stall_pc = stall[0];
  assign stall_if = stall[1];
  assign stall_id = stall[2];

  // A recorded redirect beats a live one: ID is frozen during a stall and
  // keeps re-presenting the branch it already handed us.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (br_pending_q) begin
      next_pc = br_target_q;
    end else if (br_e) begin
      next_pc = br_addr;
    end
  end

  // PC / valid / pending-redirect next state.
  always_comb begin
    pc_d         = pc_q;
    ce_d         = ce_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    if (!stall_pc) begin
      pc_d         = next_pc;
      ce_d         = 1'b1;
      br_pending_d = 1'b0;
    end else if (br_e && !br_pending_q) begin
      br_pending_d = 1'b1;
      br_target_d  = br_addr;
    end
  end

  // PC / valid / pending-redirect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= PC_RST_VAL;
      ce_q         <= 1'b0;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
    end
  end

  // Instruction hold and bubble next state. On the first frozen edge the SRAM
  // output still belongs to ID's PC, so it is captured before the SRAM
  // re-reads pc_q and kept until ID is released.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    if (stall_id) begin
      if (!hold_valid_q) begin
        hold_inst_d  = inst_sram_rdata;
        hold_valid_d = 1'b1;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
    bubble_d = stall_if && !stall_id;
  end

  // Instruction hold and bubble registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_inst_q  <= 32'h0;
      bubble_q     <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
      bubble_q     <= bubble_d;
    end
  end

  // Outputs. ce_q is low only in the reset state, so gating the PC with it
  // gives an all-zero bus during reset without a separate reset path.
  always_comb begin
    inst_sram_en    = ce_q;
    inst_sram_wen   = 4'b0000;
    inst_sram_addr  = pc_q;
    inst_sram_wdata = 32'h0;
    if_to_id_bus    = {ce_q, ce_q ? pc_q : 32'h0};
    if (bubble_q) begin
      id_inst = 32'h0;
    end else if (hold_valid_q) begin
      id_inst = hold_inst_q;
    end else begin
      id_inst = inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic [31:0] id_inst;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .STALL_WD(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed, address-dependent word.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_fn(inst_sram_addr);
  end

  // Reference model: architectural fetch PC, a remembered redirect, and the
  // contents of the ID stage register.
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_have_redir;
  logic [31:0] m_redir;
  logic        m_id_valid;
  logic [31:0] m_id_pc;
  logic        m_id_bubble;

  typedef struct {
    logic [31:0] pc;
    logic        id_chk;
    logic [31:0] id_val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc         = RESET_PC - 32'd4;
    m_ce         = 1'b0;
    m_have_redir = 1'b0;
    m_redir      = 32'h0;
    m_id_valid   = 1'b0;
    m_id_pc      = 32'h0;
    m_id_bubble  = 1'b0;
  endtask

  task automatic model_edge(input logic [5:0] s, input logic be, input logic [31:0] ba);
    logic [31:0] pc_old;
    logic        ce_old;
    exp_t        e;
    pc_old = m_pc;
    ce_old = m_ce;
    if (!s[1]) begin
      m_id_valid  = ce_old;
      m_id_pc     = pc_old;
      m_id_bubble = 1'b0;
    end else if (!s[2]) begin
      m_id_valid  = 1'b0;
      m_id_bubble = 1'b1;
    end
    if (be && !m_have_redir) begin
      m_have_redir = 1'b1;
      m_redir      = ba;
    end
    if (!s[0]) begin
      m_pc         = m_have_redir ? m_redir : pc_old + 32'd4;
      m_ce         = 1'b1;
      m_have_redir = 1'b0;
    end
    if (m_ce) begin
      e.pc     = m_pc;
      e.id_chk = m_id_valid || m_id_bubble;
      e.id_val = m_id_bubble ? 32'h0 : mem_fn(m_id_pc);
      sb.push_back(e);
    end
  endtask

  task automatic apply(input logic [5:0] s, input logic be, input logic [31:0] ba);
    stall  = s;
    br_bus = {be, ba};
    @(posedge clk);
    #1;
    model_edge(s, be, ba);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_bus"},   {31'h0, if_to_id_bus}, 64'h0);
    chk({nm, "_en"},    {63'h0, inst_sram_en}, 64'h0);
    chk({nm, "_inst"},  {32'h0, id_inst}, {32'h0, inst_sram_rdata});
    chk({nm, "_wen"},   {60'h0, inst_sram_wen}, 64'h0);
    chk({nm, "_wdata"}, {32'h0, inst_sram_wdata}, 64'h0);
  endtask

  // Monitor: whenever the DUT presents a valid fetch, compare against the
  // oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_to_id_bus[32] && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sram_addr", {32'h0, inst_sram_addr}, {32'h0, e.pc});
        chk("if_to_id_bus", {31'h0, if_to_id_bus}, {31'h0, 1'b1, e.pc});
        chk("sram_en", {63'h0, inst_sram_en}, 64'h1);
        if (e.id_chk) chk("id_inst", {32'h0, id_inst}, {32'h0, e.id_val});
      end else if (sb.size() > 0) begin
        chk("ce_missing", {63'h0, if_to_id_bus[32]}, 64'h1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pats [5];
    pats[0] = 6'b000011;
    pats[1] = 6'b000111;
    pats[2] = 6'b001111;
    pats[3] = 6'b011111;
    pats[4] = 6'b111111;

    rst    = 1'b0;
    stall  = 6'b0;
    br_bus = 33'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("rst_hold");
    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch after release.
    apply(6'b0, 1'b0, 32'h0);
    chk("first_addr", {32'h0, inst_sram_addr}, {32'h0, 32'hBFC0_0000});
    apply(6'b0, 1'b0, 32'h0);
    apply(6'b0, 1'b0, 32'h0);
    chk("addr_0008", {32'h0, inst_sram_addr}, {32'h0, 32'hBFC0_0008});

    // Branch seen while 0008 is being fetched; delay slot proceeds.
    apply(6'b0, 1'b1, 32'hBFC0_0100);
    chk("br_target", {32'h0, inst_sram_addr}, {32'h0, 32'hBFC0_0100});
    apply(6'b0, 1'b0, 32'h0);
    apply(6'b0, 1'b0, 32'h0);

    // ID frozen for three cycles.
    repeat (3) apply(6'b000111, 1'b0, 32'h0);
    apply(6'b0, 1'b0, 32'h0);
    apply(6'b0, 1'b0, 32'h0);

    // One-cycle bubble.
    apply(6'b000011, 1'b0, 32'h0);
    apply(6'b0, 1'b0, 32'h0);
    apply(6'b0, 1'b0, 32'h0);

    // Branch arriving at stall onset, held while frozen.
    repeat (4) apply(6'b000111, 1'b1, 32'h0000_2000);
    apply(6'b0, 1'b0, 32'h0);
    chk("pend_target", {32'h0, inst_sram_addr}, {32'h0, 32'h0000_2000});
    apply(6'b0, 1'b0, 32'h0);
    chk("pend_next", {32'h0, inst_sram_addr}, {32'h0, 32'h0000_2004});

    // PC wrap.
    apply(6'b0, 1'b1, 32'hFFFF_FFFC);
    apply(6'b0, 1'b0, 32'h0);
    chk("pc_wrap", {32'h0, inst_sram_addr}, 64'h0);
    apply(6'b0, 1'b0, 32'h0);

    // Randomized episodes of free-running fetch and stall bursts.
    for (int ep = 0; ep < 250; ep++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          apply(6'b0, ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC);
        end
      end else begin
        logic [5:0]  p;
        logic        be;
        logic [31:0] ba;
        int          len;
        p   = pats[$urandom_range(0, 4)];
        be  = $urandom_range(0, 1) == 1;
        ba  = $urandom & 32'hFFFF_FFFC;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) apply(p, be, ba);
        apply(6'b0, 1'b0, 32'h0);
      end
    end

    // Reset while stalled with a redirect pending.
    apply(6'b0, 1'b0, 32'h0);
    apply(6'b000111, 1'b1, 32'h1234_5678);
    apply(6'b000111, 1'b1, 32'h1234_5678);
    @(negedge clk);
    #1;
    rst    = 1'b0;
    stall  = 6'b0;
    br_bus = 33'h0;
    #1;
    check_reset("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_reset("rst_mid_edge");
    @(negedge clk);
    rst = 1'b1;
    apply(6'b0, 1'b0, 32'h0);
    chk("restart_addr", {32'h0, inst_sram_addr}, {32'h0, 32'hBFC0_0000});
    apply(6'b0, 1'b0, 32'h0);
    apply(6'b0, 1'b0, 32'h0);
    chk("restart_seq", {32'h0, inst_sram_addr}, {32'h0, 32'hBFC0_0008});

    @(negedge clk);
    #1;
    chk("sb_drained", {32'h0, 32'(sb.size())}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
